nibble_serial_sub: RTL



---
 rtl/nibble_serial_sub_pkg.sv | 12 +
 rtl/nibble_sub4.sv | 30 +++
 rtl/nibble_serial_sub.sv | 107 ++++++++++
 3 files changed

// File: rtl/nibble_serial_sub_pkg.sv
// rtl/nibble_serial_sub_pkg.sv - shared state encoding and nibble width for the serial subtractor
package nibble_serial_sub_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_sub4.sv
// rtl/nibble_sub4.sv - combinational 4-bit subtract slice, lookahead P/G form on complemented b
module nibble_sub4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       c4;

  // Subtraction is a + ~b + cin, so generate/propagate use the complemented subtrahend.
  assign g = a & ~b;
  assign p = a ^ ~b;

  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ {c3, c2, c1, cin};
  assign cout = c4;

endmodule

// File: rtl/nibble_serial_sub.sv
// rtl/nibble_serial_sub.sv - nibble-serial subtractor D = x - y - bin with start/done handshake
module nibble_serial_sub
  import nibble_serial_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             bout,
  output logic             ovf
);

  localparam int NIBS  = WIDTH / NIB_W;
  localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBS - 1);

  state_t               state;
  state_t               next_state;
  logic [WIDTH-1:0]     xs;
  logic [WIDTH-1:0]     ys;
  logic [WIDTH-1:0]     res;
  logic [WIDTH+NIB_W-1:0] res_cat;
  logic                 xmsb;
  logic                 ymsb;
  logic                 c;
  logic [IDX_W-1:0]     idx;
  logic [NIB_W-1:0]     s;
  logic                 cout;

  // Operands shift right each RUN cycle, so the slice always sees the current nibble at [3:0].
  nibble_sub4 u_slice (
    .a    (xs[NIB_W-1:0]),
    .b    (ys[NIB_W-1:0]),
    .cin  (c),
    .s    (s),
    .cout (cout)
  );

  assign res_cat = {s, res};

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (idx == LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      xs    <= '0;
      ys    <= '0;
      res   <= '0;
      xmsb  <= 1'b0;
      ymsb  <= 1'b0;
      c     <= 1'b0;
      idx   <= '0;
      D     <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            xs   <= x;
            ys   <= y;
            xmsb <= x[WIDTH-1];
            ymsb <= y[WIDTH-1];
            c    <= ~bin;
            idx  <= '0;
            res  <= '0;
          end
        end
        RUN: begin
          xs  <= xs >> NIB_W;
          ys  <= ys >> NIB_W;
          res <= res_cat[WIDTH+NIB_W-1:NIB_W];
          c   <= cout;
          idx <= idx + 1'b1;
          // The final nibble's top bit is the result sign, used for overflow.
          if (idx == LAST) begin
            D    <= res_cat[WIDTH+NIB_W-1:NIB_W];
            bout <= ~cout;
            ovf  <= (xmsb != ymsb) && (s[NIB_W-1] != xmsb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
